apb_mem_slave: RTL and testbench
================================

# apb_mem_slave

Parametrised APB slave memory: word-organised storage of DEPTH words of DATA_WIDTH bits, byte-strobed writes, programmable wait states, and PSLVERR on out-of-range or misaligned accesses. It is the next-generation peripheral-side endpoint for the APB master and is a drop-in target for any APB requester in the design.

## Interface
- DATA_WIDTH, 32, data bus width; must be 8, 16 or 32.
- ADDR_WIDTH, 12, PADDR width; it is a byte address.
- DEPTH, 256, number of words; DEPTH ≤ 2^(ADDR_WIDTH − ALSB), where ALSB = log2(DATA_WIDTH/8).
- WAIT_STATES, 0, access-phase cycles with PREADY=0 before completion; range 0..15.
- RO_WORDS, 16, words at indices 0..RO_WORDS−1 that are read-only. Used only with APB_SLV_RO_EN.
- PCLK  in  1  clock; all state changes on the rising edge.
- PRESET  in  1  asynchronous active-low reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  write byte strobes.
- PREADY  out  1  transfer completion.
- PRDATA  out  DATA_WIDTH  read data; registered.
- PSLVERR  out  1  error response; meaningful only when PREADY=1.

## Operation
- Word index: idx = PADDR >> ALSB.
- Address error (addr_err) is set when either:
  - idx ≥ DEPTH, or
  - PADDR[ALSB−1:0] ≠ 0 (misaligned).
- FSM state register, reset to IDLE. States and transitions:
  - IDLE: PSEL=1 and PENABLE=0 sampled → ACCESS, and the wait counter is cleared to 0. Otherwise stay in IDLE.
  - ACCESS, PSEL=0 sampled (protocol abort) → IDLE. No memory update, no PRDATA update.
  - ACCESS, counter < WAIT_STATES → counter increments; stay in ACCESS.
  - ACCESS, counter == WAIT_STATES → completion edge; next state is IDLE.
- PREADY is combinational: PREADY = (state==ACCESS) & PSEL & PENABLE & (counter==WAIT_STATES).
- PSLVERR is combinational: PSLVERR = PREADY & (addr_err | ro_err).
- Write, on the completion edge, when there is no error:
  - For each strobe bit k set, byte k of mem[idx] takes PWDATA byte k.
  - PSTRB = 0 is a legal no-op and gives no error.
- Writes with an error leave memory unchanged.
- Read: PRDATA is loaded on the edge that samples the setup phase (IDLE, PSEL=1, PENABLE=0, PWRITE=0).
  - Loads mem[idx] if addr_err=0, otherwise loads 0.
  - PRDATA holds its value until the next read setup. Writes never change PRDATA.
- PSTRB is ignored on reads.
- Address, control and write data are assumed stable from setup through completion (APB rule). The block does not re-sample them for PRDATA.

## Timing
- Reset (PRESET=0, asynchronous, effective immediately):
  - state=IDLE, counter=0, PRDATA=0, every mem word = 0.
  - PREADY=0 and PSLVERR=0, regardless of bus inputs.
- Setup cycle T0; access begins at T1; PREADY=1 in cycle T1+WAIT_STATES.
- Total transfer length = 2 + WAIT_STATES cycles.
- Back-to-back: a new setup may occur in the cycle immediately after completion. Full throughput is one transfer per 2+WAIT_STATES cycles.
- Read data is valid from T1 onward, so it is already stable when PREADY rises.
- Reset released mid-transfer: the block is in IDLE and ignores the remaining access phase until the next setup phase.
- A write then a read to the same word in consecutive transfers: the read returns the new data, because the write commits before the read's setup edge.
- idx = DEPTH−1 is valid; idx = DEPTH errors. There is no wrap-around.

## Configuration
- APB_SLV_RO_EN defined:
  - Words 0..RO_WORDS−1 are read-only.
  - A write to them sets ro_err, so PSLVERR=1 at completion and memory is unchanged.
  - Reads of these words are normal.
- APB_SLV_RO_EN undefined: ro_err is tied to 0, RO_WORDS is unused, and all words are writable.

## Test plan
- Reset with PSEL=PENABLE=1 held → PREADY=0, PSLVERR=0, PRDATA=0; after release, a read of every word returns 0.
- WAIT_STATES=0:
  - write 0xDEADBEEF to byte address 0x40, PSTRB=4'hF;
  - then write 0x11223344 with PSTRB=4'b0101;
  - then read 0x40 → 0xDE22BE44, with each transfer 2 cycles long.
- WAIT_STATES=3: read → PREADY low for 3 access cycles and high in the 4th; PRDATA is stable from the first access cycle.
- Error cases, each giving PSLVERR=1 with PREADY and memory unchanged:
  - read idx=DEPTH → PRDATA=0;
  - write to misaligned address 0x41;
  - write to idx=DEPTH.
- Abort: drop PSEL during a wait state → no write occurs, FSM returns to IDLE, and the following transfer completes normally.
- APB_SLV_RO_EN, RO_WORDS=16:
  - write 0xFFFFFFFF to word 3 → PSLVERR=1, and a read returns 0;
  - write to word 16 → success, and a read returns 0xFFFFFFFF.

Source files
------------

// File: rtl/apb_mem_slave_if.sv
// APB bus bundle between an APB requester and apb_mem_slave.
// The master modport drives the request side, the slave modport answers.
interface apb_mem_slave_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                      PSEL;
    logic                      PENABLE;
    logic                      PWRITE;
    logic [ADDR_WIDTH-1:0]     PADDR;
    logic [DATA_WIDTH-1:0]     PWDATA;
    logic [DATA_WIDTH/8-1:0]   PSTRB;
    logic                      PREADY;
    logic [DATA_WIDTH-1:0]     PRDATA;
    logic                      PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_mem_slave.sv
// apb_mem_slave: word-organised APB memory with byte strobes, a fixed number
// of wait states per access and PSLVERR on misaligned / out-of-range accesses.
// Optional feature macro APB_SLV_RO_EN: when defined, words 0..RO_WORDS-1
// reject writes with PSLVERR and keep their contents.
module apb_mem_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0,
    parameter int RO_WORDS    = 16
) (
    input  logic               i_pclk,
    input  logic               i_presetn,
    apb_mem_slave_if.slave     s_apb
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int ALSB   = $clog2(STRB_W);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Word counts widened by one bit so DEPTH == 2^ADDR_WIDTH still compares correctly
    localparam logic [ADDR_WIDTH:0] L_DEPTH = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] L_RO    = RO_WORDS[ADDR_WIDTH:0];
    localparam logic [3:0]          L_WAIT  = WAIT_STATES[3:0];

`ifdef APB_SLV_RO_EN
    localparam bit L_RO_EN = 1'b1;
`else
    localparam bit L_RO_EN = 1'b0;
`endif

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    state_t                  r_state;
    logic [3:0]              r_cnt;
    logic [DATA_WIDTH-1:0]   r_prdata;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   w_idx;
    logic [IDX_W-1:0]        w_memIdx;
    logic                    w_misaligned;
    logic                    w_outOfRange;
    logic                    w_addrErr;
    logic                    w_roErr;
    logic                    w_anyErr;
    logic                    w_setup;
    logic                    w_readSetup;
    logic                    w_ready;
    logic                    w_commit;

    assign w_idx        = s_apb.PADDR >> ALSB;
    assign w_memIdx     = w_idx[IDX_W-1:0];
    assign w_outOfRange = ({1'b0, w_idx} >= L_DEPTH);

    // Byte-wide buses have no sub-word address bits, so they can never be misaligned
    if (ALSB == 0) begin : g_noAlign
        assign w_misaligned = 1'b0;
    end else begin : g_align
        assign w_misaligned = |s_apb.PADDR[ALSB-1:0];
    end

    assign w_addrErr   = w_outOfRange | w_misaligned;
    assign w_roErr     = L_RO_EN & s_apb.PWRITE & ({1'b0, w_idx} < L_RO);
    assign w_anyErr    = w_addrErr | w_roErr;

    assign w_setup     = (r_state == S_IDLE) & s_apb.PSEL & ~s_apb.PENABLE;
    assign w_readSetup = w_setup & ~s_apb.PWRITE;
    assign w_ready     = (r_state == S_ACCESS) & s_apb.PSEL & s_apb.PENABLE
                         & (r_cnt == L_WAIT);
    assign w_commit    = w_ready & s_apb.PWRITE & ~w_anyErr;

    assign s_apb.PREADY  = w_ready;
    assign s_apb.PSLVERR = w_ready & w_anyErr;
    assign s_apb.PRDATA  = r_prdata;

    // Transfer sequencing, wait-state counting and read data capture at setup
    always_ff @(posedge i_pclk or negedge i_presetn) begin
        if (!i_presetn) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_prdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_setup) begin
                        r_state <= S_ACCESS;
                        r_cnt   <= 4'd0;
                    end
                    if (w_readSetup) begin
                        r_prdata <= w_addrErr ? '0 : r_mem[w_memIdx];
                    end
                end
                S_ACCESS: begin
                    if (!s_apb.PSEL) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt != L_WAIT) begin
                        r_cnt <= r_cnt + 4'd1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Storage array: cleared on reset, byte-merged on an error-free write completion
    always_ff @(posedge i_pclk or negedge i_presetn) begin
        if (!i_presetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (s_apb.PSTRB[k]) begin
                    r_mem[w_memIdx][8*k +: 8] <= s_apb.PWDATA[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Self-checking bench for apb_mem_slave: two instances (0 and 3 wait states)
// share one stimulus bus with per-instance PSEL, against a word-array model.
module tb_apb_mem_slave;

    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rstN;

    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [3:0]    pstrb;
    int            tgt;

    int  errors = 0;
    int  checks = 0;
    bit  checkEn = 1'b0;

    logic [31:0] mem [2][DEPTH];
    logic [31:0] lastRead [2];
    int          ws [2] = '{0, 3};
    bit          inAccess;
    int          acc;
    bit          expErr;

    apb_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    apb_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

    assign bus0.PSEL    = psel && (tgt == 0);
    assign bus0.PENABLE = penable;
    assign bus0.PWRITE  = pwrite;
    assign bus0.PADDR   = paddr;
    assign bus0.PWDATA  = pwdata;
    assign bus0.PSTRB   = pstrb;

    assign bus1.PSEL    = psel && (tgt == 1);
    assign bus1.PENABLE = penable;
    assign bus1.PWRITE  = pwrite;
    assign bus1.PADDR   = paddr;
    assign bus1.PWDATA  = pwdata;
    assign bus1.PSTRB   = pstrb;

    apb_mem_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
                    .WAIT_STATES(0), .RO_WORDS(16)) u_dut0 (
        .i_pclk    (clk),
        .i_presetn (rstN),
        .s_apb     (bus0.slave)
    );

    apb_mem_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
                    .WAIT_STATES(3), .RO_WORDS(16)) u_dut1 (
        .i_pclk    (clk),
        .i_presetn (rstN),
        .s_apb     (bus1.slave)
    );

    always #5 clk = ~clk;

    function automatic bit addrErr(input logic [AW-1:0] a);
        return (a[1:0] != 2'b00) || (int'(a >> 2) >= DEPTH);
    endfunction

    function automatic bit roErr(input bit w, input logic [AW-1:0] a);
`ifdef APB_SLV_RO_EN
        return w && (int'(a >> 2) < 16);
`else
        return 1'b0 && w && (a == '0);
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One APB transfer; entered and left just after a rising edge
    task automatic applyStimulus(input int t, input bit w, input logic [AW-1:0] a,
                                 input logic [31:0] d, input logic [3:0] s,
                                 input int abortAt);
        bit e;
        int idx;
        e   = addrErr(a) || roErr(w, a);
        idx = int'(a >> 2);
        tgt = t; psel = 1'b1; penable = 1'b0; pwrite = w;
        paddr = a; pwdata = d; pstrb = s;
        @(posedge clk); #1;
        if (!w) lastRead[t] = addrErr(a) ? 32'h0 : mem[t][idx];
        expErr = e; penable = 1'b1; acc = 0; inAccess = 1'b1;
        while (1) begin
            if (abortAt >= 0 && acc == abortAt) begin
                psel = 1'b0; penable = 1'b0; inAccess = 1'b0;
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
            if (acc == ws[t]) begin
                if (w && !e) begin
                    for (int k = 0; k < 4; k++)
                        if (s[k]) mem[t][idx][8*k +: 8] = d[8*k +: 8];
                end
                inAccess = 1'b0; psel = 1'b0; penable = 1'b0;
                return;
            end
            acc++;
        end
    endtask

    task automatic modelReset();
        inAccess = 1'b0;
        for (int d = 0; d < 2; d++) begin
            lastRead[d] = 32'h0;
            for (int i = 0; i < DEPTH; i++) mem[d][i] = 32'h0;
        end
    endtask

    // Every cycle, both instances' outputs must match the model's transfer state
    always @(negedge clk) begin
        if (checkEn) begin
            for (int d = 0; d < 2; d++) begin
                logic expReady;
                expReady = (rstN === 1'b1) && inAccess && (tgt == d) && (acc == ws[d]);
                checkOutput($sformatf("pready%0d", d),
                            {31'b0, (d == 0) ? bus0.PREADY : bus1.PREADY}, {31'b0, expReady});
                checkOutput($sformatf("pslverr%0d", d),
                            {31'b0, (d == 0) ? bus0.PSLVERR : bus1.PSLVERR},
                            {31'b0, expReady && expErr});
                checkOutput($sformatf("prdata%0d", d),
                            (d == 0) ? bus0.PRDATA : bus1.PRDATA, lastRead[d]);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = '0;
        pwdata = '0; pstrb = '0; tgt = 0; rstN = 1'b0; acc = 0; expErr = 1'b0;
        modelReset();
        #12 checkEn = 1'b1;
        checkOutput("rst_pready0", {31'b0, bus0.PREADY}, 32'h0);
        checkOutput("rst_pslverr1", {31'b0, bus1.PSLVERR}, 32'h0);
        checkOutput("rst_prdata0", bus0.PRDATA, 32'h0);
        tgt = 1;
        @(posedge clk); #1;
        checkOutput("rst_pready1", {31'b0, bus1.PREADY}, 32'h0);
        @(posedge clk); #1;
        rstN = 1'b1; psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1'b0, AW'(i * 4), 32'h0, 4'h0, -1);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1'b0, AW'(i * 64), 32'h0, 4'h0, -1);

        applyStimulus(0, 1'b1, 12'h040, 32'hDEADBEEF, 4'hF, -1);
        applyStimulus(0, 1'b1, 12'h040, 32'h11223344, 4'b0101, -1);
        applyStimulus(0, 1'b0, 12'h040, 32'h0, 4'hF, -1);
        checkOutput("lit_merge", bus0.PRDATA, 32'hDE22BE44);

        applyStimulus(0, 1'b1, 12'h040, 32'h00000000, 4'h0, -1);
        applyStimulus(0, 1'b0, 12'h040, 32'h0, 4'h0, -1);
        checkOutput("lit_strb0", bus0.PRDATA, 32'hDE22BE44);

        applyStimulus(0, 1'b0, 12'h400, 32'h0, 4'h0, -1);
        checkOutput("lit_rd_oob", bus0.PRDATA, 32'h0);

        applyStimulus(0, 1'b1, 12'h041, 32'hFFFFFFFF, 4'hF, -1);
        applyStimulus(0, 1'b0, 12'h040, 32'h0, 4'h0, -1);
        checkOutput("lit_misalign", bus0.PRDATA, 32'hDE22BE44);

        applyStimulus(1, 1'b1, 12'h010, 32'hCAFEF00D, 4'hF, -1);
        applyStimulus(1, 1'b0, 12'h010, 32'h0, 4'h0, -1);
        checkOutput("lit_ws3", bus1.PRDATA, 32'hCAFEF00D);

        applyStimulus(1, 1'b1, 12'h400, 32'h55555555, 4'hF, -1);
        applyStimulus(1, 1'b1, 12'h3FC, 32'h12345678, 4'hF, -1);
        applyStimulus(1, 1'b0, 12'h3FC, 32'h0, 4'h0, -1);
        checkOutput("lit_lastword", bus1.PRDATA, 32'h12345678);

        applyStimulus(1, 1'b1, 12'h020, 32'hAAAA5555, 4'hF, 1);
        applyStimulus(1, 1'b0, 12'h020, 32'h0, 4'h0, -1);
        checkOutput("lit_abort", bus1.PRDATA, 32'h0);

        applyStimulus(1, 1'b1, 12'h00C, 32'hFFFFFFFF, 4'hF, -1);
        applyStimulus(1, 1'b0, 12'h00C, 32'h0, 4'h0, -1);
`ifdef APB_SLV_RO_EN
        checkOutput("lit_ro_word3", bus1.PRDATA, 32'h0);
`else
        checkOutput("lit_ro_word3", bus1.PRDATA, 32'hFFFFFFFF);
`endif
        applyStimulus(1, 1'b1, 12'h040, 32'hFFFFFFFF, 4'hF, -1);
        applyStimulus(1, 1'b0, 12'h040, 32'h0, 4'h0, -1);
        checkOutput("lit_word16", bus1.PRDATA, 32'hFFFFFFFF);

        // Reset in the middle of a wait-stated write, released with the bus still active
        tgt = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 12'h030; pwdata = 32'h0BADF00D; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1; acc = 0; expErr = 1'b0; inAccess = 1'b1;
        @(posedge clk); #1;
        acc = 1;
        rstN = 1'b0;
        modelReset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstN = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        applyStimulus(1, 1'b0, 12'h030, 32'h0, 4'h0, -1);
        checkOutput("lit_rst_mid", bus1.PRDATA, 32'h0);
        applyStimulus(0, 1'b0, 12'h040, 32'h0, 4'h0, -1);
        checkOutput("lit_rst_clr", bus0.PRDATA, 32'h0);

        @(posedge clk); #1;
        checkEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
